// File: rtl/apb_opbridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_opbridge_pkg
// Description : Shared definitions for the APB operand bridge. Holds the
//               fixed operand-memory addresses, the idle address, the APB
//               register offsets, the bridge FSM state type and the SETUP
//               phase decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_opbridge_pkg;

  // Operand-memory port addresses. The memory acts whenever one of these
  // addresses is present, so the bridge drives ADDR_IDLE at all other times.
  localparam logic [31:0] ADDR_IDLE   = 32'h0000_0000;
  localparam logic [31:0] WADDR_OPA   = 32'h1111_0000;
  localparam logic [31:0] WADDR_OPB   = 32'h2111_0000;
  localparam logic [31:0] RADDR1_OPA  = 32'h1211_1111;
  localparam logic [31:0] RADDR2_OPA  = 32'h1312_2222;
  localparam logic [31:0] RADDR1_OPB  = 32'h2211_1111;
  localparam logic [31:0] RADDR2_OPB  = 32'h2312_2222;

  // APB register offsets (byte addresses, zero-extended PADDR).
  localparam logic [31:0] REG_WR_OPA  = 32'h0000_0000;
  localparam logic [31:0] REG_WR_OPB  = 32'h0000_0004;
  localparam logic [31:0] REG_RD_OPA  = 32'h0000_0008;
  localparam logic [31:0] REG_RD_OPB  = 32'h0000_000C;
  localparam logic [31:0] REG_STATUS  = 32'h0000_0010;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACC  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_ACC  = 3'd3,
    ST_REG_ACC = 3'd4
  } state_t;

  // What a REG_ACC cycle has to do; captured at SETUP.
  typedef enum logic [1:0] {
    REG_NONE       = 2'd0,
    REG_STATUS_RD  = 2'd1,
    REG_STATUS_CLR = 2'd2,
    REG_ERROR      = 2'd3
  } reg_kind_t;

  // Result of decoding one SETUP phase.
  typedef struct packed {
    state_t      next_state;
    reg_kind_t   kind;
    logic [31:0] waddr;
    logic [31:0] raddr1;
    logic [31:0] raddr2;
    logic        mem_wr;
  } decode_t;

  // Decode direction + offset into the follow-on state and the addresses
  // to present to the memory. Anything that is not an exact match of a
  // mapped offset in the right direction (including misaligned offsets and
  // offsets with upper address bits set) falls through to REG_ERROR.
  function automatic decode_t decode_access(input logic write, input logic [31:0] offset);
    decode_t d;
    d.next_state = ST_REG_ACC;
    d.kind       = REG_ERROR;
    d.waddr      = ADDR_IDLE;
    d.raddr1     = ADDR_IDLE;
    d.raddr2     = ADDR_IDLE;
    d.mem_wr     = 1'b0;
    case (offset)
      REG_WR_OPA: begin
        if (write) begin
          d.next_state = ST_WR_ACC;
          d.kind       = REG_NONE;
          d.waddr      = WADDR_OPA;
          d.mem_wr     = 1'b1;
        end
      end
      REG_WR_OPB: begin
        if (write) begin
          d.next_state = ST_WR_ACC;
          d.kind       = REG_NONE;
          d.waddr      = WADDR_OPB;
          d.mem_wr     = 1'b1;
        end
      end
      REG_RD_OPA: begin
        if (!write) begin
          d.next_state = ST_RD_WAIT;
          d.kind       = REG_NONE;
          d.raddr1     = RADDR1_OPA;
          d.raddr2     = RADDR2_OPA;
        end
      end
      REG_RD_OPB: begin
        if (!write) begin
          d.next_state = ST_RD_WAIT;
          d.kind       = REG_NONE;
          d.raddr1     = RADDR1_OPB;
          d.raddr2     = RADDR2_OPB;
        end
      end
      REG_STATUS: begin
        d.kind = write ? REG_STATUS_CLR : REG_STATUS_RD;
      end
      default: begin
      end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_access_counter.sv
`default_nettype none
// ============================================================================
// Module      : apb_access_counter
// Description : Wrapping access counter used for bridge debug statistics.
//               Clear has priority over increment.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               inc   - count one access this cycle
//               clr   - synchronous clear (wins over inc)
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module apb_access_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      // Natural modulo-2^WIDTH wrap.
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_operand_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_operand_bridge
// Description : APB3 slave fronting the operand memory. Translates bus
//               writes/reads into the memory's fixed-address write and dual
//               read ports, inserts one wait state for the registered memory
//               read, and keeps 16-bit write/read access counters.
// Options     : APB_OPBRIDGE_SLVERR_EN - when defined, unmapped or
//               wrong-direction accesses complete with PSLVERR=1; otherwise
//               PSLVERR is tied low and such accesses complete silently.
// Ports       : PCLK, PRESETn          - clock, async active-low reset
//               PSEL/PENABLE/PWRITE    - APB control
//               PADDR, PWDATA          - APB address / write data
//               PRDATA/PREADY/PSLVERR  - APB response
//               waddr, wdata           - memory write port
//               raddr1, raddr2         - memory read addresses
//               mem_read_data1/2       - memory read data (registered read)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_operand_bridge
  import apb_opbridge_pkg::*;
#(
  parameter int PADDR_W = 12
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [PADDR_W-1:0] PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic [31:0]        waddr,
  output logic [31:0]        wdata,
  output logic [31:0]        raddr1,
  output logic [31:0]        raddr2,
  input  logic [15:0]        mem_read_data1,
  input  logic [15:0]        mem_read_data2
);

  state_t      state;
  state_t      state_nxt;
  reg_kind_t   reg_kind;
  decode_t     dec;
  logic        setup;
  logic        wr_inc;
  logic        rd_inc;
  logic        cnt_clr;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  assign setup = PSEL & ~PENABLE;
  assign dec   = decode_access(PWRITE, 32'(PADDR));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and APB response
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    PREADY    = 1'b0;
    PRDATA    = 32'h0;
    PSLVERR   = 1'b0;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup) begin
          state_nxt = dec.next_state;
        end
      end
      ST_WR_ACC: begin
        PREADY    = 1'b1;
        // A dropped PSEL means the master abandoned the transfer: no count.
        wr_inc    = PSEL;
        state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: begin
        // Memory is sampling raddr1/2 this cycle; data arrives next cycle.
        state_nxt = PSEL ? ST_RD_ACC : ST_IDLE;
      end
      ST_RD_ACC: begin
        PREADY    = 1'b1;
        PRDATA    = {mem_read_data2, mem_read_data1};
        rd_inc    = PSEL;
        state_nxt = ST_IDLE;
      end
      ST_REG_ACC: begin
        PREADY    = 1'b1;
        if (reg_kind == REG_STATUS_RD) begin
          PRDATA = {rd_cnt, wr_cnt};
        end
        cnt_clr   = PSEL & (reg_kind == REG_STATUS_CLR);
`ifdef APB_OPBRIDGE_SLVERR_EN
        PSLVERR   = (reg_kind == REG_ERROR);
`else
        PSLVERR   = 1'b0;
`endif
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory-side address/data registers
  // Every cycle defaults to the idle address so a mapped address is only
  // ever visible for the single cycle following its SETUP phase.
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      waddr    <= ADDR_IDLE;
      wdata    <= 32'h0;
      raddr1   <= ADDR_IDLE;
      raddr2   <= ADDR_IDLE;
      reg_kind <= REG_NONE;
    end else begin
      waddr  <= ADDR_IDLE;
      raddr1 <= ADDR_IDLE;
      raddr2 <= ADDR_IDLE;
      if ((state == ST_IDLE) && setup) begin
        waddr    <= dec.waddr;
        raddr1   <= dec.raddr1;
        raddr2   <= dec.raddr2;
        reg_kind <= dec.kind;
        // wdata only follows mapped writes; it holds otherwise.
        if (dec.mem_wr) begin
          wdata <= PWDATA;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Debug access counters
  // --------------------------------------------------------------------------
  apb_access_counter #(
    .WIDTH (16)
  ) u_wr_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .inc   (wr_inc),
    .clr   (cnt_clr),
    .count (wr_cnt)
  );

  apb_access_counter #(
    .WIDTH (16)
  ) u_rd_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .inc   (rd_inc),
    .clr   (cnt_clr),
    .count (rd_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_operand_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_operand_bridge
// Description : Self-checking bench for apb_operand_bridge. Directed
//               sequences followed by randomized APB traffic, compared
//               against a transaction-level model of the bridge and a
//               registered-read model of the operand memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_operand_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [31:0] raddr1;
  logic [31:0] raddr2;
  logic [15:0] mem_read_data1;
  logic [15:0] mem_read_data2;

`ifdef APB_OPBRIDGE_SLVERR_EN
  localparam bit EXP_SLVERR = 1'b1;
`else
  localparam bit EXP_SLVERR = 1'b0;
`endif

  localparam int K_MWR  = 0;
  localparam int K_MRD  = 1;
  localparam int K_STRD = 2;
  localparam int K_CLR  = 3;
  localparam int K_ERR  = 4;

  int vectors     = 0;
  int miscompares = 0;

  // Memory contents seen at the two read address pairs.
  logic [15:0] m_a1 = 16'h0011;
  logic [15:0] m_a2 = 16'h0111;
  logic [15:0] m_b1 = 16'h1111;
  logic [15:0] m_b2 = 16'h1011;

  // Reference model state.
  logic [15:0] wr_m = 16'h0;
  logic [15:0] rd_m = 16'h0;
  int          exp_mem_wr  = 0;
  int          mem_wr_seen = 0;

  apb_operand_bridge #(
    .PADDR_W (12)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PRDATA         (PRDATA),
    .PREADY         (PREADY),
    .PSLVERR        (PSLVERR),
    .waddr          (waddr),
    .wdata          (wdata),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .mem_read_data1 (mem_read_data1),
    .mem_read_data2 (mem_read_data2)
  );

  always #5 PCLK = ~PCLK;

  // Operand memory with a registered read; unknown addresses return a
  // distinctive pattern so leaked data is visible.
  always @(posedge PCLK) begin
    mem_read_data1 <= (raddr1 == 32'h1211_1111) ? m_a1 :
                      (raddr1 == 32'h2211_1111) ? m_b1 : 16'hA5A5;
    mem_read_data2 <= (raddr2 == 32'h1312_2222) ? m_a2 :
                      (raddr2 == 32'h2312_2222) ? m_b2 : 16'h5A5A;
  end

  // Every cycle with a non-idle write address is a memory write.
  always @(negedge PCLK) begin
    if (waddr != 32'h0) mem_wr_seen <= mem_wr_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input bit wr, input logic [11:0] a);
    if (wr && (a == 12'h000 || a == 12'h004)) return K_MWR;
    if (!wr && (a == 12'h008 || a == 12'h00C)) return K_MRD;
    if (a == 12'h010) return wr ? K_CLR : K_STRD;
    return K_ERR;
  endfunction

  // One complete APB transfer; called at 1 time unit after a rising edge.
  task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd);
    int          k;
    logic [31:0] exp_rd;
    logic [31:0] exp_wa;
    k      = classify(wr, addr);
    exp_rd = 32'h0;
    exp_wa = 32'h0;
    if (k == K_MRD)  exp_rd = (addr == 12'h008) ? {m_a2, m_a1} : {m_b2, m_b1};
    if (k == K_STRD) exp_rd = {rd_m, wr_m};
    if (k == K_MWR)  exp_wa = (addr == 12'h000) ? 32'h1111_0000 : 32'h2111_0000;

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(negedge PCLK);
    check("setup_waddr",  waddr,  32'h0);
    check("setup_raddr1", raddr1, 32'h0);
    check("setup_raddr2", raddr2, 32'h0);
    check("setup_pready", 32'(PREADY), 32'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    if (k == K_MRD) begin
      check("wait_pready", 32'(PREADY), 32'h0);
      check("wait_prdata", PRDATA, 32'h0);
      check("wait_raddr1", raddr1, (addr == 12'h008) ? 32'h1211_1111 : 32'h2211_1111);
      check("wait_raddr2", raddr2, (addr == 12'h008) ? 32'h1312_2222 : 32'h2312_2222);
      @(posedge PCLK);
      @(negedge PCLK);
    end
    check("acc_pready",  32'(PREADY), 32'h1);
    check("acc_prdata",  PRDATA, exp_rd);
    check("acc_pslverr", 32'(PSLVERR), (k == K_ERR && EXP_SLVERR) ? 32'h1 : 32'h0);
    check("acc_waddr",   waddr, exp_wa);
    check("acc_raddr1",  raddr1, 32'h0);
    check("acc_raddr2",  raddr2, 32'h0);
    if (k == K_MWR) check("acc_wdata", wdata, wd);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    case (k)
      K_MWR: begin wr_m = wr_m + 16'h1; exp_mem_wr++; end
      K_MRD: rd_m = rd_m + 16'h1;
      K_CLR: begin wr_m = 16'h0; rd_m = 16'h0; end
      default: ;
    endcase
  endtask

  // Memory access abandoned by dropping PSEL in the first non-IDLE cycle.
  task automatic apb_abort(input bit wr, input logic [11:0] addr);
    int k;
    k = classify(wr, addr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = $urandom;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    if (k == K_MRD) begin
      check("abort_raddr1", raddr1, (addr == 12'h008) ? 32'h1211_1111 : 32'h2211_1111);
      check("abort_rd_pready", 32'(PREADY), 32'h0);
    end
    if (k == K_MWR) exp_mem_wr++;
    @(posedge PCLK);
    @(negedge PCLK);
    check("abort_idle_pready", 32'(PREADY), 32'h0);
    check("abort_idle_raddr1", raddr1, 32'h0);
    check("abort_idle_waddr",  waddr,  32'h0);
    @(posedge PCLK); #1;
  endtask

  logic [11:0] addr_tbl [10];

  initial begin
    addr_tbl = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                 12'h014, 12'h002, 12'h809, 12'h404, 12'hFFC};
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 12'h0; PWDATA = 32'h0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_prdata",  PRDATA, 32'h0);
    check("rst_pready",  32'(PREADY), 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("rst_waddr",   waddr,  32'h0);
    check("rst_wdata",   wdata,  32'h0);
    check("rst_raddr1",  raddr1, 32'h0);
    check("rst_raddr2",  raddr2, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Directed sequence.
    apb_xfer(1'b0, 12'h008, 32'h0);
    apb_xfer(1'b0, 12'h00C, 32'h0);
    apb_xfer(1'b1, 12'h000, 32'hDEAD_BEEF);
    apb_xfer(1'b0, 12'h010, 32'h0);
    apb_xfer(1'b1, 12'h010, 32'h0);
    apb_xfer(1'b0, 12'h010, 32'h0);
    apb_xfer(1'b0, 12'h014, 32'h0);
    apb_xfer(1'b0, 12'h000, 32'h0);
    apb_xfer(1'b1, 12'h008, 32'h1234_5678);
    apb_xfer(1'b0, 12'h010, 32'h0);

    // Reset asserted while a memory read is in its wait state.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h008;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    check("rstmid_raddr1", raddr1, 32'h0);
    check("rstmid_raddr2", raddr2, 32'h0);
    check("rstmid_pready", 32'(PREADY), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    wr_m = 16'h0; rd_m = 16'h0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 12'h010, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      bit          w;
      m_a1 = 16'($urandom); m_a2 = 16'($urandom);
      m_b1 = 16'($urandom); m_b2 = 16'($urandom);
      a = addr_tbl[$urandom_range(0, 9)];
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        apb_abort(w, w ? {9'h0, 3'($urandom_range(0, 1)) << 2} : (($urandom_range(0, 1) == 0) ? 12'h008 : 12'h00C));
      end else begin
        apb_xfer(w, a, $urandom);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK); #1;
      end
    end
    apb_xfer(1'b0, 12'h010, 32'h0);
    @(negedge PCLK);
    check("mem_wr_events", 32'(mem_wr_seen), 32'(exp_mem_wr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
